cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin between the two read clients; 0 = fixed priority with data read over instruction read.
REQ-002 SHALL have one clock, clk (input, 1 bit); all state updates on the rising edge.
REQ-003 SHALL have reset resetn (input, 1 bit), asynchronous and active-low.
REQ-004 SHALL provide inputs i_rd_req / d_rd_req (1 each): instruction-cache / data-cache read request.
REQ-005 SHALL provide inputs i_rd_type / d_rd_type (3 each) and i_rd_addr / d_rd_addr (32 each): read type and address.
REQ-006 SHALL provide outputs i_rd_rdy / d_rd_rdy (1 each): single-cycle read-accept pulse.
REQ-007 SHALL provide outputs i_ret_valid / d_ret_valid, i_ret_last / d_ret_last (1 each) and i_ret_data / d_ret_data (32 each): routed refill beats.
REQ-008 SHALL provide data-cache write-client inputs d_wr_req (1), d_wr_type (3), d_wr_addr (32), d_wr_wstrb (4) and d_wr_data (128).
REQ-009 SHALL provide output d_wr_rdy (1): single-cycle write-accept pulse.
REQ-010 SHALL provide memory-side read outputs mem_rd_req (1), mem_rd_type (3) and mem_rd_addr (32).
REQ-011 SHALL provide memory-side read inputs mem_rd_rdy, mem_ret_valid and mem_ret_last (1 each) and mem_ret_data (32).
REQ-012 SHALL provide memory-side write outputs mem_wr_req (1), mem_wr_type (3), mem_wr_addr (32), mem_wr_wstrb (4) and mem_wr_data (128).
REQ-013 SHALL provide memory-side write inputs mem_wr_rdy (1, write accepted) and mem_wr_done (1, one-cycle pulse when the write is committed).

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_DATA, WR_REQ, WR_WAIT; exactly one memory transaction is in flight at a time.
REQ-015 In IDLE, grant priority SHALL be: d_wr_req first, then reads arbitrated per RR_EN.
REQ-016 With RR_EN=1, read grant order SHALL be: after an i grant, d wins the next contest; after a d grant, i wins; the pointer resets to favour d.
REQ-017 On a grant the arbiter SHALL pulse the winner's rd_rdy or d_wr_rdy in the same IDLE cycle, latch type/addr (plus wstrb/data for writes) and owner, and move to RD_REQ or WR_REQ next cycle.
REQ-018 In IDLE the arbiter SHALL accept only one request per cycle and pulse no other client's rdy.
REQ-019 In RD_REQ, mem_rd_req SHALL be 1 with the latched type/addr held stable until mem_rd_rdy=1, then the FSM SHALL go to RD_DATA.
REQ-020 In RD_DATA, mem_ret_* SHALL be routed combinationally to the owner only; the other client's ret_valid/ret_last SHALL be 0, and its ret_data is don't-care.
REQ-021 In RD_DATA, mem_ret_valid with mem_ret_last SHALL return the FSM to IDLE on the next edge.
REQ-022 In WR_REQ, mem_wr_req SHALL be 1 with latched fields stable until mem_wr_rdy=1, then the FSM SHALL go to WR_WAIT.
REQ-023 In WR_WAIT the arbiter SHALL hold all requests until mem_wr_done=1, then return to IDLE.
REQ-024 Because of REQ-023, any read granted after a write SHALL observe that write.
REQ-025 Grant-to-mem_req latency SHALL be exactly 1 cycle; the minimum back-to-back gap between transactions is 1 IDLE cycle.
REQ-026 mem_ret_valid outside RD_DATA and mem_wr_done outside WR_WAIT SHALL be ignored, with no state change and no routing.
REQ-027 A client request dropped before its grant SHALL simply not be granted; requests are not latched before their grant.
REQ-028 mem_rd_req and mem_wr_req SHALL never be asserted in the same cycle.

Reset
REQ-029 On resetn=0, in any state including mid-burst, the FSM SHALL go to IDLE immediately, the RR pointer SHALL favour d, and the latched owner SHALL be cleared.
REQ-030 During reset all outputs SHALL be 0: every rdy, ret_valid, ret_last, ret_data, mem_*_req, and all mem address/data/type/wstrb fields.
REQ-031 After reset is released, beats still arriving from an aborted burst SHALL be ignored per REQ-026.

Verification
REQ-032 Single read: i_rd_req=1, addr 0x1C000040, type 3'b100 -> i_rd_rdy pulses in cycle 0; mem_rd_req=1 from cycle 1 with addr 0x1C000040; 4 beats 0xA0..0xA3 appear on i_ret_data, with i_ret_last on 0xA3; d_ret_valid stays 0.
REQ-033 Write priority: d_wr_req and i_rd_req and d_rd_req all asserted at once -> d_wr_rdy is granted first; no rd_rdy is pulsed until mem_wr_done; then d_rd_rdy is granted, then i_rd_rdy.
REQ-034 Round-robin: with RR_EN=1 and both read requests held continuously for 4 transactions -> grant order is d, i, d, i; with RR_EN=0 -> order is d, d, d, d.
REQ-035 Backpressure: mem_rd_rdy held 0 for 5 cycles -> mem_rd_req and mem_rd_addr stay stable for all 5 cycles; exactly one rdy pulse is issued to the client.
REQ-036 Stray beats and reset: a mem_ret_valid pulse in IDLE -> no client ret_valid; resetn=0 in RD_DATA after 2 beats -> all outputs 0 and state IDLE; remaining beats are ignored.
REQ-037 RAW ordering: write to 0x00001000 followed immediately by d_rd_req to 0x00001000 -> mem_rd_req does not rise before the cycle after mem_wr_done.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache read clients and the D-cache write client
// onto one memory port, keeping exactly one memory transaction in flight.
module cache_mem_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic         mem_ret_last,
  input  logic [31:0]  mem_ret_data,
  output logic         mem_wr_req,
  output logic [2:0]   mem_wr_type,
  output logic [31:0]  mem_wr_addr,
  output logic [3:0]   mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic         mem_wr_rdy,
  input  logic         mem_wr_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic       RR_ON    = (RR_EN != 0);

  state_e         state_q, state_d;
  logic           rr_q, rr_d;          // 1: the d read client wins the next contest
  logic [1:0]     owner_q, owner_d;
  logic [2:0]     type_q, type_d;
  logic [31:0]    addr_q, addr_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           gnt_i_s, gnt_d_s, gnt_w_s;
  logic           rd_data_s;

  // State, arbitration pointer and latched transaction fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b1;
      owner_q <= OWN_NONE;
      type_q  <= 3'd0;
      addr_q  <= 32'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 128'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  // Grant selection and next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    gnt_i_s = 1'b0;
    gnt_d_s = 1'b0;
    gnt_w_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_wr_req) begin
          gnt_w_s = 1'b1;
          type_d  = d_wr_type;
          addr_d  = d_wr_addr;
          wstrb_d = d_wr_wstrb;
          wdata_d = d_wr_data;
          owner_d = OWN_D;
          state_d = S_WR_REQ;
        end else if (d_rd_req && (!i_rd_req || !RR_ON || rr_q)) begin
          gnt_d_s = 1'b1;
          type_d  = d_rd_type;
          addr_d  = d_rd_addr;
          owner_d = OWN_D;
          rr_d    = 1'b0;
          state_d = S_RD_REQ;
        end else if (i_rd_req) begin
          gnt_i_s = 1'b1;
          type_d  = i_rd_type;
          addr_d  = i_rd_addr;
          owner_d = OWN_I;
          rr_d    = 1'b1;
          state_d = S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (mem_rd_rdy) begin
          state_d = S_RD_DATA;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_DATA: begin
        if (mem_ret_valid && mem_ret_last) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_WR_REQ: begin
        if (mem_wr_rdy) begin
          state_d = S_WR_WAIT;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_WAIT: begin
        if (mem_wr_done) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Accept pulses are combinational in the IDLE cycle; force them low while in reset.
  assign i_rd_rdy = gnt_i_s & resetn;
  assign d_rd_rdy = gnt_d_s & resetn;
  assign d_wr_rdy = gnt_w_s & resetn;

  assign mem_rd_req   = (state_q == S_RD_REQ);
  assign mem_rd_type  = type_q;
  assign mem_rd_addr  = addr_q;
  assign mem_wr_req   = (state_q == S_WR_REQ);
  assign mem_wr_type  = type_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_wstrb = wstrb_q;
  assign mem_wr_data  = wdata_q;

  assign rd_data_s   = (state_q == S_RD_DATA);
  assign i_ret_valid = rd_data_s && (owner_q == OWN_I) && mem_ret_valid;
  assign i_ret_last  = rd_data_s && (owner_q == OWN_I) && mem_ret_last;
  assign i_ret_data  = (rd_data_s && (owner_q == OWN_I)) ? mem_ret_data : 32'd0;
  assign d_ret_valid = rd_data_s && (owner_q == OWN_D) && mem_ret_valid;
  assign d_ret_last  = rd_data_s && (owner_q == OWN_D) && mem_ret_last;
  assign d_ret_data  = (rd_data_s && (owner_q == OWN_D)) ? mem_ret_data : 32'd0;

endmodule
